// File: rtl/packet_sorter.sv
// packet_sorter: buffers one packet, bubble-sorts it in place (one compare per cycle), then streams it out.
// Optional macro PACKET_SORTER_EARLY_EXIT_EN ends the sort after a pass that made no swaps.
module packet_sorter #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              val_i,
  input  logic              desc_i,
  output logic              ready_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic              val_o,
  input  logic              ready_i,
  output logic [AWIDTH:0]   len_o,
  output logic              ovf_o,
  output logic              busy_o
);

  localparam int MAXLEN = 2 ** AWIDTH;

  typedef logic [AWIDTH:0] cnt_t;
  typedef logic [AWIDTH-1:0] addr_t;
  typedef enum logic [1:0] {
    S_RECV = 2'd0,
    S_SORT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam cnt_t MAXLEN_C = cnt_t'(MAXLEN);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DWIDTH-1:0] r_mem [MAXLEN];
  cnt_t              r_cnt;
  logic              r_open;
  logic              r_desc;
  logic              r_ovf;
  addr_t             r_pass;
  addr_t             r_j;
  cnt_t              r_ptr;
  logic              r_ready;
  logic              r_val;
  logic              r_sop;
  logic              r_eop;
  logic [DWIDTH-1:0] r_data;
  cnt_t              r_len;
  logic              r_busy;

  logic              w_acc;
  logic              w_close;
  logic              w_wr_en;
  addr_t             w_wr_addr;
  cnt_t              w_cnt_new;
  logic              w_ovf_set;
  addr_t             w_j1;
  logic [DWIDTH-1:0] w_a;
  logic [DWIDTH-1:0] w_b;
  logic              w_ooo;
  logic              w_jlast;
  logic              w_plast;
  logic              w_sort_end;
  logic              w_out_adv;
  logic              w_out_done;
  logic              w_load;

  assign w_acc      = val_i & r_ready;
  assign w_close    = w_acc & eop_i & (sop_i | r_open);
  assign w_j1       = r_j + AWIDTH'(1);
  assign w_a        = r_mem[r_j];
  assign w_b        = r_mem[w_j1];
  // Strict comparison keeps equal words in place, so the sort is stable.
  assign w_ooo      = (r_state == S_SORT) & (r_desc ? (w_a < w_b) : (w_a > w_b));
  assign w_jlast    = (cnt_t'(r_j) == (r_cnt - cnt_t'(2) - cnt_t'(r_pass)));
  assign w_plast    = (cnt_t'(r_pass) == (r_cnt - cnt_t'(2)));
  assign w_out_adv  = (r_state == S_OUT) & (~r_val | ready_i);
  assign w_out_done = w_out_adv & r_val & r_eop;
  assign w_load     = w_out_adv & ~w_out_done & (r_ptr < r_cnt);

`ifdef PACKET_SORTER_EARLY_EXIT_EN
  logic r_swapped;

  // Tracks whether the current pass has swapped anything yet.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_swapped <= 1'b0;
    end else if ((r_state != S_SORT) || w_jlast) begin
      r_swapped <= 1'b0;
    end else if (w_ooo) begin
      r_swapped <= 1'b1;
    end else begin
      r_swapped <= r_swapped;
    end
  end

  assign w_sort_end = w_jlast & (w_plast | (~r_swapped & ~w_ooo));
`else
  assign w_sort_end = w_jlast & w_plast;
`endif

  // Write decode for incoming beats and the word count they produce.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    w_cnt_new = r_cnt;
    w_ovf_set = 1'b0;
    if (w_acc && sop_i) begin
      w_wr_en   = 1'b1;
      w_cnt_new = cnt_t'(1);
    end else if (w_acc && r_open) begin
      if (r_cnt == MAXLEN_C) begin
        w_ovf_set = 1'b1;
      end else begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_cnt[AWIDTH-1:0];
        w_cnt_new = r_cnt + cnt_t'(1);
      end
    end else begin
      w_wr_en = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RECV: begin
        if (w_close) w_state_nxt = (w_cnt_new >= cnt_t'(2)) ? S_SORT : S_OUT;
        else         w_state_nxt = S_RECV;
      end
      S_SORT: begin
        if (w_sort_end) w_state_nxt = S_OUT;
        else            w_state_nxt = S_SORT;
      end
      S_OUT: begin
        if (w_out_done) w_state_nxt = S_RECV;
        else            w_state_nxt = S_OUT;
      end
      default: w_state_nxt = S_RECV;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_state <= S_RECV;
    else           r_state <= w_state_nxt;
  end

  // Packet storage: input writes in RECV, in-place swaps in SORT; not reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= data_i;
    end else if (w_ooo) begin
      r_mem[r_j]  <= w_b;
      r_mem[w_j1] <= w_a;
    end
  end

  // Packet bookkeeping: count, open flag, direction and overflow.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_cnt  <= '0;
      r_open <= 1'b0;
      r_desc <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_acc && sop_i) begin
      r_cnt  <= w_cnt_new;
      r_open <= ~eop_i;
      r_desc <= desc_i;
      r_ovf  <= 1'b0;
    end else if (w_acc && r_open) begin
      r_cnt  <= w_cnt_new;
      r_open <= ~eop_i;
      r_ovf  <= r_ovf | w_ovf_set;
    end
  end

  // Bubble-sort pass and pair indices.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_pass <= '0;
      r_j    <= '0;
    end else if (r_state != S_SORT) begin
      r_pass <= '0;
      r_j    <= '0;
    end else if (w_jlast) begin
      r_pass <= r_pass + AWIDTH'(1);
      r_j    <= '0;
    end else begin
      r_j    <= w_j1;
    end
  end

  // Output read pointer; it runs one word ahead of what the consumer has taken.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)              r_ptr <= '0;
    else if (r_state != S_OUT)  r_ptr <= '0;
    else if (w_load)            r_ptr <= r_ptr + cnt_t'(1);
  end

  // Registered outputs.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_val   <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_data  <= '0;
      r_len   <= '0;
    end else begin
      r_ready <= (w_state_nxt == S_RECV);
      r_busy  <= (w_state_nxt != S_RECV);
      if (w_out_done) begin
        r_val <= 1'b0;
        r_sop <= 1'b0;
        r_eop <= 1'b0;
      end else if (w_load) begin
        r_val  <= 1'b1;
        r_data <= r_mem[r_ptr[AWIDTH-1:0]];
        r_sop  <= (r_ptr == cnt_t'(0));
        r_eop  <= (r_ptr == (r_cnt - cnt_t'(1)));
        r_len  <= r_cnt;
      end
    end
  end

  assign ready_o = r_ready;
  assign busy_o  = r_busy;
  assign val_o   = r_val;
  assign sop_o   = r_sop;
  assign eop_o   = r_eop;
  assign data_o  = r_data;
  assign len_o   = r_len;
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_packet_sorter.sv
// Scoreboard bench for packet_sorter: one AWIDTH=3 instance and one AWIDTH=2 instance for overflow.
module tb_packet_sorter;

  typedef int wl_t[8];
  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
    logic [7:0] len;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_n, sel;
  logic [7:0] data_i;
  logic       sop_i, eop_i, val_i, desc_i, ready_i;

  logic       rdy1, sop1, eop1, val1, ovf1, busy1;
  logic [7:0] d1;
  logic [3:0] len1;
  logic       rdy2, sop2, eop2, val2, ovf2, busy2;
  logic [7:0] d2;
  logic [2:0] len2;
  logic       val_in1, val_in2;

  assign val_in1 = val_i & ~sel;
  assign val_in2 = val_i & sel;

  packet_sorter #(.DWIDTH(8), .AWIDTH(3)) u_dut (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(data_i), .sop_i(sop_i), .eop_i(eop_i),
    .val_i(val_in1), .desc_i(desc_i), .ready_o(rdy1), .data_o(d1), .sop_o(sop1),
    .eop_o(eop1), .val_o(val1), .ready_i(ready_i), .len_o(len1), .ovf_o(ovf1), .busy_o(busy1)
  );

  packet_sorter #(.DWIDTH(8), .AWIDTH(2)) u_dut2 (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(data_i), .sop_i(sop_i), .eop_i(eop_i),
    .val_i(val_in2), .desc_i(desc_i), .ready_o(rdy2), .data_o(d2), .sop_o(sop2),
    .eop_o(eop2), .val_o(val2), .ready_i(ready_i), .len_o(len2), .ovf_o(ovf2), .busy_o(busy2)
  );

  logic       m_ready, m_sop, m_eop, m_val, m_ovf, m_busy;
  logic [7:0] m_data, m_len;
  assign m_ready = sel ? rdy2 : rdy1;
  assign m_sop   = sel ? sop2 : sop1;
  assign m_eop   = sel ? eop2 : eop1;
  assign m_val   = sel ? val2 : val1;
  assign m_ovf   = sel ? ovf2 : ovf1;
  assign m_busy  = sel ? busy2 : busy1;
  assign m_data  = sel ? d2 : d1;
  assign m_len   = sel ? {5'd0, len2} : {4'd0, len1};

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  int   exp_wait;
  logic exp_ovf;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit out_of_order(input int a, input int b, input bit desc);
    return desc ? (a < b) : (a > b);
  endfunction

  // Number of SORT cycles for the given stored words.
  function automatic int sort_cycles(input int a_in[$], input bit desc);
    int a[$];
    int n, cnt;
    bit sw;
    a = a_in;
    n = a.size();
    if (n < 2) return 0;
`ifdef PACKET_SORTER_EARLY_EXIT_EN
    cnt = 0;
    for (int p = 0; p <= n - 2; p++) begin
      sw = 1'b0;
      for (int j = 0; j <= n - 2 - p; j++) begin
        cnt++;
        if (out_of_order(a[j], a[j+1], desc)) begin
          int t = a[j];
          a[j] = a[j+1];
          a[j+1] = t;
          sw = 1'b1;
        end
      end
      if (!sw) break;
    end
    return cnt;
`else
    cnt = n * (n - 1) / 2;
    sw = 1'b0;
    return cnt + int'(sw);
`endif
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
    int b = 0;
    while (m_ready !== 1'b1 && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (b >= 200) chk("ready_timeout", 32'(m_ready), 32'd1);
    data_i = d; sop_i = s; eop_i = e; val_i = 1'b1;
    @(negedge clk);
    val_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
  endtask

  task automatic send_pkt(input int n, input wl_t w, input bit desc, input bit junk);
    int maxlen, m, v, j;
    int st[$];
    exp_t e;
    maxlen = sel ? 4 : 8;
    desc_i = desc;
    for (int i = 0; i < n; i++) send_beat(8'(w[i]), (i == 0), (i == n - 1));
    desc_i = 1'b0;
    m = (n > maxlen) ? maxlen : n;
    for (int i = 0; i < m; i++) st.push_back(w[i]);
    exp_wait = sort_cycles(st, desc) + 1;
    for (int i = 1; i < m; i++) begin
      v = st[i];
      j = i - 1;
      while (j >= 0 && out_of_order(st[j], v, desc)) begin
        st[j+1] = st[j];
        j--;
      end
      st[j+1] = v;
    end
    for (int i = 0; i < m; i++) begin
      e.d = 8'(st[i]); e.s = (i == 0); e.e = (i == m - 1); e.len = 8'(m);
      sb.push_back(e);
    end
    exp_ovf = (n > maxlen);
    if (junk) begin
      data_i = 8'hEE; sop_i = 1'b1; eop_i = 1'b1; val_i = 1'b1;
    end
  endtask

  task automatic recv_pkt(input int stall_idx, input int stall_len, input int stop_after);
    int k = 0, st = 0, waitc = 0, b = 0;
    bit seen = 1'b0;
    logic [7:0] held = 8'd0;
    exp_t e;
    ready_i = 1'b1;
    while (k < stop_after && b < 500) begin
      if (m_val) begin
        if (!seen) begin
          seen = 1'b1;
          chk("sort_latency", 32'(waitc), 32'(exp_wait));
          val_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
        end
        if (k == stall_idx && st < stall_len) begin
          if (st == 0) held = m_data;
          else chk("stall_hold", 32'(m_data), 32'(held));
          ready_i = 1'b0;
          st++;
        end else begin
          if (k == stall_idx && st > 0) chk("stall_hold", 32'(m_data), 32'(held));
          if (sb.size() == 0) begin
            chk("extra_word", 32'(m_data), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("data", 32'(m_data), 32'(e.d));
            chk("sop",  32'(m_sop),  32'(e.s));
            chk("eop",  32'(m_eop),  32'(e.e));
            chk("len",  32'(m_len),  32'(e.len));
          end
          ready_i = 1'b1;
          k++;
        end
      end else if (!seen) begin
        waitc++;
      end
      if (k < stop_after) begin
        @(negedge clk);
        b++;
      end
    end
    if (b >= 500) chk("out_timeout", 32'(k), 32'(stop_after));
  endtask

  task automatic finish_pkt();
    @(negedge clk);
    chk("val_drop",   32'(m_val),   32'd0);
    chk("ready_back", 32'(m_ready), 32'd1);
    chk("ovf",        32'(m_ovf),   32'(exp_ovf));
    chk("sb_empty",   32'(sb.size()), 32'd0);
  endtask

  initial begin
    sel = 1'b0; data_i = 8'd0; sop_i = 1'b0; eop_i = 1'b0; val_i = 1'b0;
    desc_i = 1'b0; ready_i = 1'b1; arst_n = 1'b0;
    exp_wait = 0; exp_ovf = 1'b0;
    #12;
    chk("rst_ready", 32'(m_ready), 32'd0);
    chk("rst_val",   32'(m_val),   32'd0);
    chk("rst_flags", 32'({m_sop, m_eop, m_busy, m_ovf}), 32'd0);
    chk("rst_len",   32'(m_len),   32'd0);
    chk("rst_data",  32'(m_data),  32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_rise", 32'(m_ready), 32'd1);
    @(negedge clk);

    // Ascending, full rate
    send_pkt(4, '{5, 3, 7, 1, 0, 0, 0, 0}, 1'b0, 1'b0);
    chk("busy_sort", 32'(m_busy), 32'd1);
    recv_pkt(-1, 0, 4);
    finish_pkt();

    // Descending with a 3-cycle stall on the second word; junk beats while not ready
    send_pkt(3, '{2, 9, 4, 0, 0, 0, 0, 0}, 1'b1, 1'b1);
    recv_pkt(1, 3, 3);
    finish_pkt();

    // Single word
    send_pkt(1, '{8'hAA, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0);
    recv_pkt(-1, 0, 1);
    finish_pkt();

    // Orphan beat dropped, then a packet restarted by a mid-packet sop
    send_beat(8'h55, 1'b0, 1'b1);
    send_beat(8'd3, 1'b1, 1'b0);
    send_beat(8'd4, 1'b0, 1'b0);
    send_pkt(2, '{2, 1, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0);
    recv_pkt(-1, 0, 2);
    finish_pkt();

    // Presorted packet
    send_pkt(5, '{1, 2, 3, 4, 5, 0, 0, 0}, 1'b0, 1'b0);
    recv_pkt(-1, 0, 5);
    finish_pkt();

    // Duplicates, descending
    send_pkt(4, '{4, 2, 4, 2, 0, 0, 0, 0}, 1'b1, 1'b0);
    recv_pkt(-1, 0, 4);
    finish_pkt();

    // Overflow on the AWIDTH=2 instance, then a clean packet clears ovf
    sel = 1'b1;
    @(negedge clk);
    send_pkt(6, '{6, 5, 4, 3, 2, 1, 0, 0}, 1'b0, 1'b0);
    recv_pkt(-1, 0, 4);
    finish_pkt();
    send_pkt(2, '{2, 1, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0);
    recv_pkt(-1, 0, 2);
    finish_pkt();
    sel = 1'b0;
    @(negedge clk);

    // Reset after two of four output words
    send_pkt(4, '{4, 3, 2, 1, 0, 0, 0, 0}, 1'b0, 1'b0);
    recv_pkt(-1, 0, 2);
    #2 arst_n = 1'b0;
    #1;
    chk("rst_mid_val",  32'(m_val),  32'd0);
    chk("rst_mid_busy", 32'(m_busy), 32'd0);
    sb.delete();
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    send_pkt(2, '{8, 1, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0);
    recv_pkt(-1, 0, 2);
    finish_pkt();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_sorter.md
PACKET_SORTER -- requirements
Module: packet_sorter

Interface
REQ-001 Parameter DWIDTH, default 8: width of each data word in bits, range 1 to 32.
REQ-002 Parameter AWIDTH, default 8: address width; maximum packet length is MAXLEN = 2**AWIDTH words.
REQ-003 clk_i  in  1  single clock; all logic samples on its rising edge.
REQ-004 arst_n_i  in  1  asynchronous active-low reset.
REQ-005 data_i  in  DWIDTH  input word.
REQ-006 sop_i, eop_i, val_i  in  1 each  input start-of-packet, end-of-packet and word-valid qualifiers.
REQ-007 desc_i  in  1  sort order: 0 = ascending, 1 = descending; sampled on the sop beat.
REQ-008 ready_o  out  1  block accepts input words; high only in RECV.
REQ-009 data_o  out  DWIDTH  sorted output word.
REQ-010 sop_o, eop_o, val_o  out  1 each  output start-of-packet, end-of-packet and word-valid qualifiers.
REQ-011 ready_i  in  1  downstream accepts the current output word.
REQ-012 len_o  out  AWIDTH+1  stored word count; valid while val_o is high.
REQ-013 ovf_o  out  1  sticky flag: the last packet exceeded MAXLEN words.
REQ-014 busy_o  out  1  high in SORT and OUT.

Function
REQ-015 The block SHALL implement a state machine with states RECV, SORT and OUT.
REQ-016 An input beat SHALL be accepted when val_i and ready_o are both high.
REQ-017 In RECV, an accepted beat with sop_i SHALL write the word to address 0, set count to 1, latch desc_i and clear ovf_o.
REQ-018 In RECV, an accepted beat without sop_i SHALL be dropped if no packet is open.
REQ-019 A sop_i beat arriving mid-packet SHALL discard the open packet and start a new one.
REQ-020 Accepted non-sop beats SHALL be written at address count, then count SHALL increment.
REQ-021 If count already equals MAXLEN, the word SHALL be dropped and ovf_o set.
REQ-022 An accepted eop_i beat SHALL close the packet after its word is stored.
REQ-023 On close, the state SHALL move to SORT if count >= 2, otherwise directly to OUT.
REQ-024 A beat with both sop_i and eop_i high SHALL form a one-word packet.
REQ-025 SORT SHALL run a bubble sort that performs one adjacent-pair compare per cycle.
REQ-026 Pass p (from 0) SHALL compare pairs (j, j+1) for j = 0 to count-2-p.
REQ-027 A pair SHALL be swapped in the same cycle when it is out of order for the latched direction.
REQ-028 Equal words SHALL never be swapped, so the sort is stable.
REQ-029 Pass count-2 is the last pass; after it, the state SHALL move to OUT.
REQ-030 In OUT, words SHALL be presented from address 0 up to count-1.
REQ-031 The first word SHALL appear with val_o high on the first clock edge after OUT is entered.
REQ-032 sop_o SHALL be high on the first word and eop_o on the last word; both are high for a one-word packet.
REQ-033 The output pointer SHALL advance only on a cycle with val_o and ready_i both high.
REQ-034 While val_o is high and ready_i is low, data_o, sop_o, eop_o and len_o SHALL hold stable.
REQ-035 After the eop_o word is accepted, the state SHALL return to RECV and ready_o SHALL rise on the next cycle.
REQ-036 Input beats presented while ready_o is low SHALL be ignored.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 Assertion of arst_n_i SHALL immediately force state RECV and clear count, all pointers and the latched direction.
REQ-039 During reset, outputs SHALL be: ready_o = 0, val_o = 0, sop_o = 0, eop_o = 0, busy_o = 0, ovf_o = 0, len_o = 0, data_o = 0.
REQ-040 ready_o SHALL rise on the first clock edge after reset deasserts.
REQ-041 Memory contents need not be reset.
REQ-042 A reset during SORT or OUT SHALL abandon the packet with no further output words.

Configuration
REQ-043 Macro PACKET_SORTER_EARLY_EXIT_EN SHALL select the sort-termination rule.
REQ-044 With the macro defined, a completed pass with zero swaps SHALL end SORT on the cycle after its last compare.
REQ-045 Without the macro, SORT SHALL always take exactly count*(count-1)/2 cycles.
REQ-046 Output data SHALL be identical in both builds.

Verification
REQ-047 Ascending sort: AWIDTH=3, packet 5,3,7,1, desc=0, ready_i=1 -> output 1,3,5,7; sop_o on 1, eop_o on 7, len_o=4; SORT lasts 6 cycles (macro off).
REQ-048 Descending sort with stall: packet 2,9,4, desc=1, ready_i low for 3 cycles on the second word -> output 9,4,2 with word 4 held stable while stalled.
REQ-049 Single word: one beat 0xAA with sop_i and eop_i -> no SORT cycles; one output 0xAA with sop_o=eop_o=1, len_o=1.
REQ-050 Overflow: AWIDTH=2, 6-word packet 6,5,4,3,2,1 -> ovf_o=1, len_o=4, output 3,4,5,6.
REQ-051 Early exit: macro defined, presorted packet 1,2,3,4,5 -> SORT lasts 4 cycles; with macro off it lasts 10 cycles.
REQ-052 Reset mid-run: assert arst_n_i in OUT after 2 of 4 words -> val_o drops immediately; a following packet 8,1 is output as 1,8.
